// File: rtl/divider_fp16_seq_pkg.sv
// Shared binary16 constants, divider FSM state type and packing helpers.
package fp16_pkg;

  localparam int FP16_BIAS  = 15;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

  // One quotient bit per DIV cycle; twelve bits give the integer bit,
  // ten fraction bits and one extra bit for the single normalisation shift.
  localparam int DIV_STEPS = 12;
  localparam logic [3:0] DIV_LAST = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Zero exponent field means "treat as zero" (no subnormals), on either side.
  function automatic logic fp16_is_special(input logic [15:0] a, input logic [15:0] b);
    return (a[14:10] == 5'h00) || (b[14:10] == 5'h00);
  endfunction

  // Result for the zero-operand cases, in priority order: 0/0, x/0, 0/x.
  function automatic logic [15:0] fp16_special(input logic [15:0] a, input logic [15:0] b);
    logic sign;
    logic [15:0] res;
    sign = a[15] ^ b[15];
    if ((b[14:10] == 5'h00) && (a[14:10] == 5'h00)) begin
      res = FP16_QNAN;
    end else if (b[14:10] == 5'h00) begin
      res = {sign, FP16_EXP_MAX, 10'h000};
    end else begin
      res = {sign, 15'h0000};
    end
    return res;
  endfunction

  // Pack a sign, a signed 7-bit biased exponent and a truncated mantissa,
  // saturating to infinity on overflow and flushing to zero on underflow.
  function automatic logic [15:0] fp16_pack(input logic sign,
                                            input logic signed [6:0] exp,
                                            input logic [9:0] mant);
    logic [15:0] res;
    if (exp >= 7'sd31) begin
      res = {sign, FP16_EXP_MAX, 10'h000};
    end else if (exp <= 7'sd0) begin
      res = {sign, 15'h0000};
    end else begin
      res = {sign, exp[4:0], mant};
    end
    return res;
  endfunction

endpackage

// File: rtl/divider_fp16_seq_if.sv
// Operand/result handshake bundle for the sequential fp16 divider.
interface divider_fp16_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, z
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, z
  );
endinterface

// File: rtl/divider_fp16_seq_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
module div_step_12bit (
  input  logic [11:0] r,
  input  logic [10:0] mb,
  output logic        q_bit,
  output logic [11:0] r_next
);

  logic [11:0] diff;

  // Remainder always stays below 2*mb, so the shifted value fits 12 bits.
  always_comb begin
    diff   = r - {1'b0, mb};
    q_bit  = 1'b0;
    r_next = {r[10:0], 1'b0};
    if (r >= {1'b0, mb}) begin
      q_bit  = 1'b1;
      r_next = {diff[10:0], 1'b0};
    end else begin
      q_bit  = 1'b0;
      r_next = {r[10:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider_fp16_seq.sv
// Sequential binary16 divider z = a / b, one restoring quotient bit per clock.
module divider_fp16_seq
  import fp16_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  divider_fp16_seq_if.slave  bus
);

  div_state_t        state;
  div_state_t        state_next;
  logic [11:0]       r;
  logic [11:0]       q;
  logic [10:0]       mb;
  logic [3:0]        cnt;
  logic signed [6:0] e;
  logic              sign_z;
  logic [15:0]       z_reg;
  logic              out_valid_reg;

  logic              step_q;
  logic [11:0]       step_r;
  logic              special;
  logic [6:0]        e_accept;
  logic signed [6:0] norm_exp;
  logic [9:0]        norm_mant;
  logic [15:0]       norm_z;

  div_step_12bit u_step (
    .r      (r),
    .mb     (mb),
    .q_bit  (step_q),
    .r_next (step_r)
  );

  assign special  = fp16_is_special(bus.a, bus.b);
  // Modular 7-bit arithmetic yields the correct two's complement in [-16, 46].
  assign e_accept = {2'b00, bus.a[14:10]} - {2'b00, bus.b[14:10]} + 7'd15;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.z         = z_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept, 12 DIV steps, one NORM, then hold in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = special ? DONE : DIV;
        end else begin
          state_next = IDLE;
        end
      end
      DIV: begin
        if (cnt == DIV_LAST) begin
          state_next = NORM;
        end else begin
          state_next = DIV;
        end
      end
      NORM: begin
        state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Normalise: quotient lies in (0.5, 2), so at most one left shift is needed.
  always_comb begin
    norm_exp  = e;
    norm_mant = q[10:1];
    if (q[11]) begin
      norm_exp  = e;
      norm_mant = q[10:1];
    end else begin
      norm_exp  = e - 7'sd1;
      norm_mant = q[9:0];
    end
    norm_z = fp16_pack(sign_z, norm_exp, norm_mant);
  end

  // Datapath registers: operand capture, iteration, result and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r             <= 12'h000;
      q             <= 12'h000;
      mb            <= 11'h000;
      cnt           <= 4'd0;
      e             <= 7'sd0;
      sign_z        <= 1'b0;
      z_reg         <= 16'h0000;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign_z <= bus.a[15] ^ bus.b[15];
            mb     <= {1'b1, bus.b[9:0]};
            e      <= $signed(e_accept);
            q      <= 12'h000;
            cnt    <= 4'd0;
            r      <= {1'b0, 1'b1, bus.a[9:0]};
            if (special) begin
              z_reg         <= fp16_special(bus.a, bus.b);
              out_valid_reg <= 1'b1;
            end
          end
        end
        DIV: begin
          q   <= {q[10:0], step_q};
          r   <= step_r;
          cnt <= cnt + 4'd1;
        end
        NORM: begin
          z_reg         <= norm_z;
          out_valid_reg <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_fp16_seq.sv
// Directed self-checking bench for the sequential fp16 divider.
module tb_divider_fp16_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  divider_fp16_seq_if bus_if ();

  divider_fp16_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a pair, accept it, wait (bounded) for out_valid.
  // lat counts edges including the accept edge.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        output int lat, output logic [15:0] zv, output logic ready_low);
    bus_if.a        = av;
    bus_if.b        = bv;
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    lat       = 1;
    ready_low = 1'b1;
    while (bus_if.out_valid !== 1'b1 && lat < 40) begin
      if (bus_if.in_ready !== 1'b0) ready_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (bus_if.in_ready !== 1'b0) ready_low = 1'b0;
    zv = bus_if.z;
  endtask

  task automatic consume();
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.a         = 16'h3C00;
    bus_if.b         = 16'h3C00;
    bus_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid);
    end
    checks++;
    if (bus_if.z !== 16'h0000) begin
      failures++; $display("FAIL reset_z: got %h expected 0000", bus_if.z);
    end
    checks++;
    if (bus_if.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b expected 1", bus_if.in_ready);
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_unit();
    int lat; logic [15:0] zv; logic rl;
    run_op(16'h3C00, 16'h3C00, lat, zv, rl);
    checks++;
    if (zv !== 16'h3C00) begin
      failures++; $display("FAIL unit_z: got %h expected 3c00", zv);
    end
    checks++;
    if (lat !== 14) begin
      failures++; $display("FAIL unit_latency: got %0d expected 14", lat);
    end
    checks++;
    if (rl !== 1'b1) begin
      failures++; $display("FAIL unit_in_ready_low: in_ready rose while busy");
    end
    consume();
    checks++;
    if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL unit_release: got in_ready=%b out_valid=%b expected 1/0",
               bus_if.in_ready, bus_if.out_valid);
    end
  endtask

  task automatic test_normal();
    logic [15:0] va [0:4];
    logic [15:0] vb [0:4];
    logic [15:0] vz [0:4];
    int lat; logic [15:0] zv; logic rl;
    va = '{16'h4600, 16'h3C00, 16'hC400, 16'h7800, 16'h0400};
    vb = '{16'h4000, 16'h4200, 16'h4000, 16'h0400, 16'h7800};
    vz = '{16'h4200, 16'h3555, 16'hC000, 16'h7C00, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], lat, zv, rl);
      checks++;
      if (zv !== vz[i]) begin
        failures++; $display("FAIL normal_z[%0d] %h/%h: got %h expected %h", i, va[i], vb[i], zv, vz[i]);
      end
      checks++;
      if (lat !== 14) begin
        failures++; $display("FAIL normal_latency[%0d]: got %0d expected 14", i, lat);
      end
      consume();
    end
  endtask

  task automatic test_special();
    logic [15:0] va [0:2];
    logic [15:0] vb [0:2];
    logic [15:0] vz [0:2];
    int lat; logic [15:0] zv; logic rl;
    va = '{16'h3C00, 16'h0000, 16'h8000};
    vb = '{16'h0000, 16'h0000, 16'h4000};
    vz = '{16'h7C00, 16'h7E00, 16'h8000};
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], lat, zv, rl);
      checks++;
      if (zv !== vz[i]) begin
        failures++; $display("FAIL special_z[%0d] %h/%h: got %h expected %h", i, va[i], vb[i], zv, vz[i]);
      end
      checks++;
      if (lat !== 1) begin
        failures++; $display("FAIL special_latency[%0d]: got %0d expected 1", i, lat);
      end
      consume();
    end
  endtask

  task automatic test_back_pressure();
    int lat; logic [15:0] zv; logic rl;
    run_op(16'h4600, 16'h4000, lat, zv, rl);
    checks++;
    if (zv !== 16'h4200) begin
      failures++; $display("FAIL bp_first_z: got %h expected 4200", zv);
    end
    for (int i = 0; i < 5; i++) begin
      bus_if.in_valid = i[0];
      bus_if.a        = 16'h0000;
      bus_if.b        = 16'h0000;
      @(posedge clk); #1;
      checks++;
      if (bus_if.z !== 16'h4200 || bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got z=%h out_valid=%b in_ready=%b expected 4200/1/0",
                 i, bus_if.z, bus_if.out_valid, bus_if.in_ready);
      end
    end
    bus_if.in_valid = 1'b0;
    consume();
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1",
               bus_if.out_valid, bus_if.in_ready);
    end
    run_op(16'h3C00, 16'h4200, lat, zv, rl);
    checks++;
    if (zv !== 16'h3555 || lat !== 14) begin
      failures++; $display("FAIL bp_next_op: got z=%h lat=%0d expected 3555/14", zv, lat);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] zv; logic rl;
    run_op(16'h3C00, 16'h0000, lat, zv, rl);
    consume();
    run_op(16'h8000, 16'h4000, lat, zv, rl);
    checks++;
    if (zv !== 16'h8000 || lat !== 1) begin
      failures++; $display("FAIL b2b_special: got z=%h lat=%0d expected 8000/1", zv, lat);
    end
    consume();
    run_op(16'hC400, 16'h4000, lat, zv, rl);
    checks++;
    if (zv !== 16'hC000 || lat !== 14) begin
      failures++; $display("FAIL b2b_normal: got z=%h lat=%0d expected c000/14", zv, lat);
    end
    consume();
  endtask

  task automatic test_reset_mid_div();
    int lat; logic [15:0] zv; logic rl;
    bus_if.a        = 16'h3C00;
    bus_if.b        = 16'h4200;
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.out_ready = 1'b0;
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.z !== 16'h0000 || bus_if.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: got out_valid=%b z=%h in_ready=%b expected 0/0000/1",
               bus_if.out_valid, bus_if.z, bus_if.in_ready);
    end
    run_op(16'h4600, 16'h4000, lat, zv, rl);
    checks++;
    if (zv !== 16'h4200 || lat !== 14) begin
      failures++; $display("FAIL after_reset_op: got z=%h lat=%0d expected 4200/14", zv, lat);
    end
    consume();
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.a         = 16'h0000;
    bus_if.b         = 16'h0000;
    test_reset();
    test_unit();
    test_normal();
    test_special();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
